alu_result_buffer: RTL and testbench

Downstream stage of the ALU logic unit. It captures each 32-bit ALU result with its 4-bit ALUop and destination register index, derives zero/negative flags, and presents the entry to writeback. A 2-entry buffer decouples the ALU from writeback stalls through a valid/ready handshake, preserving order without losing results. A retired-logic-op counter supports performance observation.

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_result_entry.sv | 14 +
 rtl/alu_result_buffer.sv | 67 ++++++
 tb/tb_alu_result_buffer.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALUop constants, buffer states and result-entry type
package alu_pkg;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_NOR = 4'b0111;
  localparam logic [1:0] LOGIC_CLASS = 2'b01;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} buf_state_t;
  typedef struct packed {
    logic [31:0] result;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        zero;
    logic        neg;
  } alu_entry_t;
endpackage

// File: rtl/alu_result_entry.sv
// alu_result_entry: one buffer slot with load enable, cleared on reset
module alu_result_entry #(
  parameter type T = alu_pkg::alu_entry_t
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  T     d,
  output T     q
);
  always_ff @(posedge clk)
    if (reset) q <= '0;
    else if (load) q <= d;
endmodule

// File: rtl/alu_result_buffer.sv
// alu_result_buffer: 2-entry FIFO between ALU and writeback with stored zero/neg flags
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RW    = 5,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic [3:0]       in_op,
  input  logic [RW-1:0]    in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_op,
  output logic [RW-1:0]    out_rd,
  output logic             out_wen,
  output logic             out_zero,
  output logic             out_neg,
  output logic [CNTW-1:0]  logic_cnt
);
  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [3:0]       op;
    logic [RW-1:0]    rd;
    logic             zero;
    logic             neg;
  } entry_t;
  buf_state_t state;
  entry_t head, tail, in_entry, head_d;
  logic push, pop, head_load, tail_load;
  assign in_ready  = state != TWO;
  assign out_valid = state != EMPTY;
  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;
  assign in_entry = '{result: in_result, op: in_op, rd: in_rd,
                      zero: in_result == '0, neg: in_result[WIDTH-1]};
  // head refills from tail when draining TWO, otherwise from the incoming entry
  assign head_d    = state == TWO ? tail : in_entry;
  assign head_load = state == TWO ? pop : push && (state == EMPTY || pop);
  assign tail_load = push && !pop && state == ONE;
  alu_result_entry #(.T(entry_t)) u_head (
    .clk(clk), .reset(reset), .load(head_load), .d(head_d), .q(head)
  );
  alu_result_entry #(.T(entry_t)) u_tail (
    .clk(clk), .reset(reset), .load(tail_load), .d(in_entry), .q(tail)
  );
  always_ff @(posedge clk)
    if (reset) state <= EMPTY;
    else state <= state == EMPTY ? (push ? ONE : EMPTY) :
                  state == ONE   ? (push && !pop ? TWO : pop && !push ? EMPTY : ONE) :
                                   (pop ? ONE : TWO);
  always_ff @(posedge clk)
    if (reset) logic_cnt <= '0;
    else if (pop && head.op[3:2] == LOGIC_CLASS && !(&logic_cnt))
      logic_cnt <= logic_cnt + CNTW'(1);
  assign out_result = head.result;
  assign out_op     = head.op;
  assign out_rd     = head.rd;
  assign out_zero   = head.zero;
  assign out_neg    = head.neg;
  assign out_wen    = out_valid && head.rd != '0;
endmodule

// File: tb/tb_alu_result_buffer.sv
// tb_alu_result_buffer: directed scoreboard bench for the 2-entry ALU result buffer
module tb_alu_result_buffer;
  localparam int WIDTH = 32;
  localparam int RW = 5;
  localparam int CNTW = 4;
  logic clk = 0, reset = 1, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, out_wen, out_zero, out_neg;
  logic [WIDTH-1:0] in_result = '0, out_result;
  logic [3:0] in_op = '0, out_op;
  logic [RW-1:0] in_rd = '0, out_rd;
  logic [CNTW-1:0] logic_cnt;
  typedef struct {
    logic [WIDTH-1:0] result;
    logic [3:0] op;
    logic [RW-1:0] rd;
  } exp_t;
  exp_t q[$];
  int total = 0, bad = 0, cnt = 0;

  alu_result_buffer #(.WIDTH(WIDTH), .RW(RW), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_op(in_op), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_op(out_op), .out_rd(out_rd), .out_wen(out_wen), .out_zero(out_zero),
    .out_neg(out_neg), .logic_cnt(logic_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare outputs against the scoreboard mid-cycle, then advance the model by one edge
  task automatic step();
    logic push, pop;
    @(negedge clk);
    chk("in_ready", in_ready, q.size() < 2);
    chk("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("out_result", out_result, q[0].result);
      chk("out_op", out_op, q[0].op);
      chk("out_rd", out_rd, q[0].rd);
      chk("out_wen", out_wen, q[0].rd != 0);
      chk("out_zero", out_zero, q[0].result == 0);
      chk("out_neg", out_neg, q[0].result[WIDTH-1]);
    end else chk("out_wen_idle", out_wen, 0);
    chk("logic_cnt", logic_cnt, cnt);
    push = in_valid && q.size() < 2;
    pop = out_ready && q.size() != 0;
    if (reset) begin
      q.delete();
      cnt = 0;
    end else begin
      if (pop) begin
        if (q[0].op[3:2] == 2'b01 && cnt != (1 << CNTW) - 1) cnt++;
        void'(q.pop_front());
      end
      if (push) q.push_back('{in_result, in_op, in_rd});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] r, input logic [3:0] o, input logic [RW-1:0] d);
    in_valid = v;
    in_result = r;
    in_op = o;
    in_rd = d;
  endtask

  initial begin
    step();
    step();
    reset = 0;
    chk("rst_result", out_result, 0);
    chk("rst_op", out_op, 0);
    chk("rst_rd", out_rd, 0);
    chk("rst_zero", out_zero, 0);
    chk("rst_neg", out_neg, 0);
    // single zero-result logic op
    out_ready = 1;
    drive(1, 32'h0, 4'b0100, 5'd3);
    step();
    drive(0, 32'hdead_beef, 4'b0000, 5'd7);
    step();
    step();
    chk("cnt_after_first", logic_cnt, 1);
    // fill to TWO under backpressure, then drain
    out_ready = 0;
    drive(1, 32'h8000_0001, 4'b0000, 5'd5);
    step();
    drive(1, 32'h1, 4'b0101, 5'd0);
    step();
    drive(0, 32'h0, 4'b0000, 5'd0);
    step();
    chk("full_in_ready", in_ready, 0);
    out_ready = 1;
    repeat (3) step();
    // continuous stream
    for (int i = 0; i < 8; i++) begin
      drive(1, $urandom, 4'(i), 5'(i + 1));
      step();
    end
    drive(0, 32'h0, 4'b0000, 5'd0);
    repeat (2) step();
    // simultaneous push and pop in ONE
    out_ready = 0;
    drive(1, 32'h1234_5678, 4'b0110, 5'd9);
    step();
    out_ready = 1;
    drive(1, 32'hffff_0000, 4'b0111, 5'd10);
    step();
    drive(0, 32'h0, 4'b0000, 5'd0);
    chk("one_head", out_result, 32'hffff_0000);
    repeat (2) step();
    // reset while TWO with handshakes pending
    out_ready = 0;
    drive(1, 32'h5, 4'b0100, 5'd1);
    step();
    drive(1, 32'h6, 4'b0101, 5'd2);
    step();
    out_ready = 1;
    drive(1, 32'h7, 4'b0110, 5'd3);
    reset = 1;
    step();
    reset = 0;
    drive(0, 32'h0, 4'b0000, 5'd0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_cnt", logic_cnt, 0);
    step();
    // saturate the logic-op counter
    for (int i = 0; i < 20; i++) begin
      drive(1, $urandom, 4'b0100 | 4'(i % 4), 5'(i));
      step();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, $urandom, 4'b0010, 5'd4);
      step();
    end
    drive(0, 32'h0, 4'b0000, 5'd0);
    repeat (3) step();
    chk("cnt_saturated", logic_cnt, 4'hF);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
